// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, reset address and the
// instruction-step constant, plus the branch offset helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_STEP        = 32'd4;

  // Word offset to byte offset, sign-extended to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;

  modport master (output imem_addr, input  imem_inst);
  modport slave  (input  imem_addr, output imem_inst);
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next fetch address: redirect target calculation and jr > jump > branch >
// sequential priority, all qualified by the held instruction's valid bit.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] fetch_pc,
  input  logic [31:0] pc_plus4,
  input  logic        valid,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misalign_req
);

  always_comb begin
    next_pc      = fetch_pc + INST_STEP;
    redirect     = 1'b0;
    misalign_req = 1'b0;
    if (valid) begin
      if (jr) begin
        // A misaligned jr never redirects; the caller halts instead.
        if (jr_target[1:0] != 2'b00) begin
          misalign_req = 1'b1;
        end else begin
          redirect = 1'b1;
          next_pc  = jr_target;
        end
      end else if (jump) begin
        redirect = 1'b1;
        next_pc  = {pc_plus4[31:28], jump_idx, 2'b00};
      end else if (br_taken) begin
        redirect = 1'b1;
        next_pc  = pc_plus4 + branch_offset(br_imm);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: fetch PC register, decode output register
// and BOOT/RUN/HALT control.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [15:0]         br_imm,
  input  logic                jump,
  input  logic [25:0]         jump_idx,
  input  logic                jr,
  input  logic [31:0]         jr_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         inst_out,
  output logic [31:0]         pc_out,
  output logic [31:0]         pc_plus4,
  output logic                inst_valid,
  output logic                misalign
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         misalign_req;

  assign imem.imem_addr = fetch_pc;
  assign pc_plus4       = pc_out + INST_STEP;

  next_pc_sel u_next_pc_sel (
    .fetch_pc     (fetch_pc),
    .pc_plus4     (pc_plus4),
    .valid        (inst_valid),
    .br_taken     (br_taken),
    .br_imm       (br_imm),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .jr           (jr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .misalign_req (misalign_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      fetch_pc   <= RESET_PC;
      inst_out   <= '0;
      pc_out     <= RESET_PC;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: begin
          inst_out   <= imem.imem_inst;
          pc_out     <= fetch_pc;
          inst_valid <= 1'b1;
          fetch_pc   <= next_pc;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          if (misalign_req) begin
            misalign   <= 1'b1;
            inst_valid <= 1'b0;
            state      <= ST_HALT;
          end else if (redirect || !stall) begin
            // The word fetched alongside a redirect is wrong-path: latch it as a bubble.
            inst_out   <= imem.imem_inst;
            pc_out     <= fetch_pc;
            inst_valid <= !redirect;
            fetch_pc   <= next_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
